sel_multi: RTL

- Parametrised successor to the scoreboard digit selector.
- Maps the VGA raster position (h_index, v_index) to one of DIGITS evenly spaced glyph slots on a single text row.
- Outputs the registered slot code, a hit flag and the pixel offset inside the glyph, so the font ROM stage can address the glyph directly.
- Adds per-slot blinking driven by a frame counter, used for the score-edit and pause modes.

---
 rtl/sel_multi.sv | 120 ++++++++++++
 1 files changed

// File: rtl/sel_multi.sv
// Raster-to-glyph-slot selector: registered slot code, in-glyph pixel offsets
// and per-slot blinking paced by a frame-start counter.
module sel_slot #(
    parameter int X_LO    = 250,
    parameter int GLYPH_W = 32,
    parameter int GXW     = 5
) (
    input  logic [9:0]     h_index,
    input  logic           row_hit,
    output logic           hit,
    output logic [GXW-1:0] gx
);
    localparam int X_HI = X_LO + GLYPH_W;
    localparam logic [GXW-1:0] XL = GXW'(X_LO);

    // 32-bit bounds: a window starting at or past 1024 simply never matches
    assign hit = row_hit && ({22'd0, h_index} >= 32'(X_LO)) && ({22'd0, h_index} < 32'(X_HI));
    assign gx  = h_index[GXW-1:0] - XL;
endmodule

module sel_multi #(
    parameter int DIGITS       = 4,
    parameter int X0           = 250,
    parameter int PITCH        = 70,
    parameter int Y0           = 50,
    parameter int GLYPH_W      = 32,
    parameter int GLYPH_H      = 32,
    parameter int BLINK_FRAMES = 30,
    localparam int GXW = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1,
    localparam int GYW = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1
) (
    input  logic              clk_sel,
    input  logic              rst_sel_n,
    input  logic [9:0]        h_index,
    input  logic [9:0]        v_index,
    input  logic [DIGITS-1:0] blink_mask,
    output logic [2:0]        sel_digit,
    output logic              sel_hit,
    output logic [GXW-1:0]    glyph_x,
    output logic [GYW-1:0]    glyph_y,
    output logic              blink_phase
);
    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);

    logic                        row_hit;
    logic [DIGITS-1:0]           hit;
    logic [DIGITS-1:0][GXW-1:0]  gx_arr;
    logic [GYW-1:0]              gy;

    assign row_hit = ({22'd0, v_index} >= 32'(Y0)) && ({22'd0, v_index} < 32'(Y0 + GLYPH_H));
    assign gy      = v_index[GYW-1:0] - GYW'(Y0);

    for (genvar k = 0; k < DIGITS; k++) begin : g_slot
        sel_slot #(.X_LO(X0 + k * PITCH), .GLYPH_W(GLYPH_W), .GXW(GXW)) u_slot (
            .h_index (h_index),
            .row_hit (row_hit),
            .hit     (hit[k]),
            .gx      (gx_arr[k])
        );
    end

    logic [2:0]     nxt_sel;
    logic [GXW-1:0] nxt_gx;
    logic [GYW-1:0] nxt_gy;
    logic           nxt_blank;

    // Scan high to low so the lowest-indexed overlapping slot wins
    always_comb begin
        nxt_sel   = '0;
        nxt_gx    = '0;
        nxt_gy    = '0;
        nxt_blank = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (hit[k]) begin
                nxt_sel   = 3'(k + 1);
                nxt_gx    = gx_arr[k];
                nxt_gy    = gy;
                nxt_blank = blink_mask[k] & blink_phase;
            end
        end
        if (nxt_blank) begin
            nxt_sel = '0;
            nxt_gx  = '0;
            nxt_gy  = '0;
        end
    end

    logic          fs, fs_q;
    logic [CW-1:0] frame_cnt;

    assign fs = (h_index == 10'd0) && (v_index == 10'd0);

    always_ff @(posedge clk_sel or negedge rst_sel_n) begin
        if (!rst_sel_n) begin
            sel_digit   <= '0;
            sel_hit     <= 1'b0;
            glyph_x     <= '0;
            glyph_y     <= '0;
            blink_phase <= 1'b0;
            frame_cnt   <= '0;
            fs_q        <= 1'b0;
        end else begin
            sel_digit <= nxt_sel;
            sel_hit   <= (nxt_sel != 3'd0);
            glyph_x   <= nxt_gx;
            glyph_y   <= nxt_gy;
            fs_q      <= fs;
            // Count only the rising edge of (0,0) so a held origin counts once
            if (fs && !fs_q) begin
                if (frame_cnt == CNT_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + CW'(1);
                end
            end
        end
    end
endmodule
